// File: rtl/aes_decryp_iter_core_if.sv
// Bus bundle for the iterative AES decryption core: cipher-text input,
// round-key request/response and plain-text output.
//
// Handshake rule for every channel: a transfer happens on a rising aes_clk
// edge where the valid and the ready of that channel are both 1. A source
// keeps its valid and data stable until that edge. The round-key channel
// uses key_req_o/key_sel_o as the request. key_vld_i answers that
// cipher_key_i holds round key key_sel_o, and the core consumes the key on
// that edge. Plain text stays valid and stable until plain_text_rdy_i.
interface aes_decryp_iter_core_if #(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4
);
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_text_i;
  logic                                 cipher_text_vld_i;
  logic                                 cipher_text_rdy_o;
  logic                                 key_req_o;
  logic [3:0]                           key_sel_o;
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_key_i;
  logic                                 key_vld_i;
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] plain_text_o;
  logic                                 plain_text_vld_o;
  logic                                 plain_text_rdy_i;

  // Environment side: supplies cipher text and keys, takes plain text.
  modport master (
    output cipher_text_i, cipher_text_vld_i, cipher_key_i, key_vld_i, plain_text_rdy_i,
    input  cipher_text_rdy_o, key_req_o, key_sel_o, plain_text_o, plain_text_vld_o
  );

  // Core side.
  modport slave (
    input  cipher_text_i, cipher_text_vld_i, cipher_key_i, key_vld_i, plain_text_rdy_i,
    output cipher_text_rdy_o, key_req_o, key_sel_o, plain_text_o, plain_text_vld_o
  );
endinterface

// File: rtl/aes_decryp_iter_core.sv
// Iterative AES inverse cipher: one round per accepted round key, counting
// rnd down from NR to 0. Matrix element [r][c] holds block byte 4*c+r.
module aes_decryp_iter_core #(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4,
  parameter int KEY_LEN = 128
) (
  input  logic                  aes_clk,
  input  logic                  resetn,
  input  logic                  aes_core_en,
  aes_decryp_iter_core_if.slave bus,
  output logic                  aes_busy_o,
  output logic [1:0]            dbg_state
);
  localparam int NR = 6 + KEY_LEN / 32;

  typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  if (!(KEY_LEN == 128 || KEY_LEN == 192 || KEY_LEN == 256)) begin : g_bad_key_len
    $error("aes_decryp_iter_core: KEY_LEN %0d is not 128, 192 or 256", KEY_LEN);
  end
  if (NO_ROWS != 4 || NO_COLS != 4) begin : g_bad_shape
    $error("aes_decryp_iter_core: only a 4x4 state matrix is supported");
  end

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // GF(2^8) multiply by 2, reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  // Row r rotates right by r: new column c takes old column c-r (mod 4).
  function automatic mat_t inv_shift_rows(input mat_t m);
    mat_t o;
    logic [1:0] ri, ci, src;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ri = 2'(r);
        ci = 2'(c);
        src = ci - ri;
        o[ri][ci] = m[ri][src];
      end
    end
    return o;
  endfunction

  function automatic mat_t inv_sub_bytes(input mat_t m);
    mat_t o;
    logic [1:0] ri, ci;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ri = 2'(r);
        ci = 2'(c);
        o[ri][ci] = INV_SBOX[m[ri][ci]];
      end
    end
    return o;
  endfunction

  function automatic mat_t inv_mix_columns(input mat_t m);
    mat_t o;
    logic [1:0] ci;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      ci = 2'(c);
      a0 = m[0][ci];
      a1 = m[1][ci];
      a2 = m[2][ci];
      a3 = m[3][ci];
      o[0][ci] = m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3);
      o[1][ci] = m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3);
      o[2][ci] = m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3);
      o[3][ci] = m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3);
    end
    return o;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  mat_t       st_q, st_d;
  mat_t       pt_q, pt_d;
  logic       pt_vld_q, pt_vld_d;
  logic       ct_rdy;
  mat_t       round_in;

  // Shared front half of every middle/final round.
  assign round_in = inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.cipher_key_i;

  assign ct_rdy                = resetn && aes_core_en && (state_q == IDLE);
  assign bus.cipher_text_rdy_o = ct_rdy;
  assign bus.key_req_o         = (state_q == ROUND);
  // rnd only moves on entering ROUND or consuming a key, so it already
  // holds its last value whenever the core is outside ROUND.
  assign bus.key_sel_o         = rnd_q;
  assign bus.plain_text_o      = pt_q;
  assign bus.plain_text_vld_o  = pt_vld_q;
  assign aes_busy_o            = (state_q != IDLE);
  assign dbg_state             = state_q;

  // Next-state and datapath decode; disable outranks every handshake.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    st_d     = st_q;
    pt_d     = pt_q;
    pt_vld_d = pt_vld_q;
    if (!aes_core_en) begin
      state_d  = IDLE;
      pt_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cipher_text_vld_i && ct_rdy) begin
            st_d    = bus.cipher_text_i;
            rnd_d   = 4'(NR);
            state_d = ROUND;
          end
        end
        ROUND: begin
          if (bus.key_vld_i) begin
            if (rnd_q == 4'(NR)) begin
              st_d  = st_q ^ bus.cipher_key_i;
              rnd_d = rnd_q - 4'd1;
            end else if (rnd_q != 4'd0) begin
              st_d  = inv_mix_columns(round_in);
              rnd_d = rnd_q - 4'd1;
            end else begin
              pt_d     = round_in;
              pt_vld_d = 1'b1;
              state_d  = DONE;
            end
          end
        end
        DONE: begin
          if (bus.plain_text_rdy_i) begin
            pt_vld_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge aes_clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rnd_q    <= 4'd0;
      st_q     <= '0;
      pt_q     <= '0;
      pt_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      st_q     <= st_d;
      pt_q     <= pt_d;
      pt_vld_q <= pt_vld_d;
    end
  end
endmodule

// File: tb/tb_aes_decryp_iter_core.sv
// Bench for aes_decryp_iter_core: one instance per key length sharing the
// stimulus, a FIPS-197 inverse-cipher reference model built from GF(2^8)
// arithmetic, and a round-key responder.
module tb_aes_decryp_iter_core;
  typedef logic [3:0][3:0][7:0] mat_t;

  // ---------------- clock / reset ----------------
  logic aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;
  logic resetn, aes_core_en;

  // ---------------- shared stimulus and DUTs ----------------
  mat_t       ct, key;
  logic       ct_vld, key_vld, pt_rdy;
  logic [1:0] sel;
  logic [2:0] busy;
  logic [1:0] dbg0, dbg1, dbg2;

  aes_decryp_iter_core_if if_k128 ();
  aes_decryp_iter_core_if if_k192 ();
  aes_decryp_iter_core_if if_k256 ();

  assign if_k128.cipher_text_i = ct;
  assign if_k192.cipher_text_i = ct;
  assign if_k256.cipher_text_i = ct;
  assign if_k128.cipher_key_i  = key;
  assign if_k192.cipher_key_i  = key;
  assign if_k256.cipher_key_i  = key;
  assign if_k128.cipher_text_vld_i = ct_vld && (sel == 2'd0);
  assign if_k192.cipher_text_vld_i = ct_vld && (sel == 2'd1);
  assign if_k256.cipher_text_vld_i = ct_vld && (sel == 2'd2);
  assign if_k128.key_vld_i = key_vld && (sel == 2'd0);
  assign if_k192.key_vld_i = key_vld && (sel == 2'd1);
  assign if_k256.key_vld_i = key_vld && (sel == 2'd2);
  assign if_k128.plain_text_rdy_i = pt_rdy && (sel == 2'd0);
  assign if_k192.plain_text_rdy_i = pt_rdy && (sel == 2'd1);
  assign if_k256.plain_text_rdy_i = pt_rdy && (sel == 2'd2);

  aes_decryp_iter_core #(.KEY_LEN(128)) u_dut_128 (
    .aes_clk(aes_clk), .resetn(resetn), .aes_core_en(aes_core_en),
    .bus(if_k128.slave), .aes_busy_o(busy[0]), .dbg_state(dbg0));
  aes_decryp_iter_core #(.KEY_LEN(192)) u_dut_192 (
    .aes_clk(aes_clk), .resetn(resetn), .aes_core_en(aes_core_en),
    .bus(if_k192.slave), .aes_busy_o(busy[1]), .dbg_state(dbg1));
  aes_decryp_iter_core #(.KEY_LEN(256)) u_dut_256 (
    .aes_clk(aes_clk), .resetn(resetn), .aes_core_en(aes_core_en),
    .bus(if_k256.slave), .aes_busy_o(busy[2]), .dbg_state(dbg2));

  logic       obs_rdy, obs_kreq, obs_pvld, obs_busy;
  logic [3:0] obs_ksel;
  mat_t       obs_pt;

  // Observe the instance currently selected.
  always_comb begin
    case (sel)
      2'd1: begin
        obs_rdy = if_k192.cipher_text_rdy_o; obs_kreq = if_k192.key_req_o;
        obs_ksel = if_k192.key_sel_o; obs_pt = if_k192.plain_text_o;
        obs_pvld = if_k192.plain_text_vld_o; obs_busy = busy[1];
      end
      2'd2: begin
        obs_rdy = if_k256.cipher_text_rdy_o; obs_kreq = if_k256.key_req_o;
        obs_ksel = if_k256.key_sel_o; obs_pt = if_k256.plain_text_o;
        obs_pvld = if_k256.plain_text_vld_o; obs_busy = busy[2];
      end
      default: begin
        obs_rdy = if_k128.cipher_text_rdy_o; obs_kreq = if_k128.key_req_o;
        obs_ksel = if_k128.key_sel_o; obs_pt = if_k128.plain_text_o;
        obs_pvld = if_k128.plain_text_vld_o; obs_busy = busy[0];
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_tab[256];
  logic [7:0]   isbox_tab[256];
  logic [127:0] rk[15];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Forward S-box from the field inverse plus affine map; inverse by table flip.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_tab[x] = s;
      isbox_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; nk = key words.
  task automatic key_expand(input logic [255:0] k, input int nk);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_cipher(input logic [127:0] c, input int nr);
    logic [7:0] s[16], t[16], a[4], coef[4];
    logic [127:0] o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int k = 0; k < 16; k++) s[k] = c[127-8*k -: 8] ^ rk[nr][127-8*k -: 8];
    for (int rd = nr - 1; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++) t[r+4*cc] = s[r + 4*((cc - r + 4) % 4)];
      for (int k = 0; k < 16; k++) t[k] = isbox_tab[t[k]] ^ rk[rd][127-8*k -: 8];
      if (rd > 0) begin
        for (int cc = 0; cc < 4; cc++) begin
          for (int j = 0; j < 4; j++) a[j] = t[j+4*cc];
          for (int r = 0; r < 4; r++) begin
            s[r+4*cc] = 8'h00;
            for (int j = 0; j < 4; j++) s[r+4*cc] = s[r+4*cc] ^ gmul(coef[(j - r + 4) % 4], a[j]);
          end
        end
      end else begin
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  function automatic mat_t to_mat(input logic [127:0] b);
    mat_t m;
    for (int k = 0; k < 16; k++) m[2'(k % 4)][2'(k / 4)] = b[127-8*k -: 8];
    return m;
  endfunction

  // ---------------- round-key responder ----------------
  int         key_mode = 0;   // 0: always valid, 1: random valid
  logic       prev_req = 1'b0;
  logic       prev_vld = 1'b1;
  logic [3:0] prev_ksel = 4'd0;

  always @(negedge aes_clk) begin
    if (key_mode == 1 && prev_req && !prev_vld && obs_kreq)
      check("key_sel_hold", 128'(obs_ksel), 128'(prev_ksel));
    prev_ksel = obs_ksel;
    prev_req  = obs_kreq && aes_core_en && resetn;
    key       = (obs_ksel <= 4'd14) ? to_mat(rk[obs_ksel]) : '0;
    key_vld   = (key_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    prev_vld  = key_vld;
  end

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic [1:0] s, input logic [255:0] k, input logic [127:0] c);
    sel = s;
    key_expand(k, 4 + 2*int'(s));
    @(negedge aes_clk);
    ct = to_mat(c);
    ct_vld = 1'b1;
    #1 check("ct_rdy_idle", 128'(obs_rdy), 128'(1));
    @(negedge aes_clk);
    ct_vld = 1'b0;
  endtask

  // Entered at the negedge right after the acceptance edge.
  task automatic wait_vld(input bit lat_chk, input int nr);
    int edges;
    edges = 0;
    while (!obs_pvld && edges < 400) begin
      if (lat_chk && obs_kreq) check("key_sel_seq", 128'(obs_ksel), 128'(nr - edges));
      @(negedge aes_clk);
      edges++;
    end
    check("vld_seen", 128'(obs_pvld), 128'(1));
    if (lat_chk) check("latency", 128'(edges), 128'(nr + 1));
    check("key_req_done", 128'(obs_kreq), 128'(0));
  endtask

  task automatic release_out();
    pt_rdy = 1'b1;
    @(negedge aes_clk);
    pt_rdy = 1'b0;
    check("vld_clear", 128'(obs_pvld), 128'(0));
    check("busy_clear", 128'(obs_busy), 128'(0));
  endtask

  task automatic run_block(input logic [1:0] s, input logic [255:0] k, input logic [127:0] c,
                           input logic [127:0] exp_pt, input bit lat_chk);
    exp_q.push_back(exp_pt);
    start_block(s, k, c);
    wait_vld(lat_chk, 10 + 2*int'(s));
    check("plain_text", obs_pt, to_mat(exp_q.pop_front()));
    release_out();
  endtask

  task automatic ref_decrypt(input logic [1:0] s, input logic [255:0] k, input logic [127:0] c,
                             output logic [127:0] p);
    key_expand(k, 4 + 2*int'(s));
    p = inv_cipher(c, 10 + 2*int'(s));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- test sequence ----------------
  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_KAT = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [127:0] exp_pt, ct_rand;
    logic [255:0] k_rand;
    logic [1:0]   s_rand;
    int n;
    resetn = 1'b0; aes_core_en = 1'b1; ct = '0; ct_vld = 1'b0; pt_rdy = 1'b0; sel = 2'd0;
    build_tables();
    repeat (2) @(negedge aes_clk);

    // Reset state of every instance, with enable high and reset still low.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("rst_ct_rdy", 128'(obs_rdy), 128'(0));
      check("rst_key_req", 128'(obs_kreq), 128'(0));
      check("rst_key_sel", 128'(obs_ksel), 128'(0));
      check("rst_pt_vld", 128'(obs_pvld), 128'(0));
      check("rst_busy", 128'(obs_busy), 128'(0));
      check("rst_pt", obs_pt, 128'(0));
    end
    sel = 2'd0;
    @(negedge aes_clk);
    resetn = 1'b1;

    // Known-answer blocks, key always valid.
    run_block(2'd0, {KEY_KAT[255:128], 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_KAT, 1'b1);
    run_block(2'd1, {KEY_KAT[255:64], 64'h0},   128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_KAT, 1'b1);
    run_block(2'd2, KEY_KAT,                    128'h8ea2b7ca516745bfeafc49904b496089, PT_KAT, 1'b1);

    // Random blocks against the model.
    for (int i = 0; i < 6; i++) begin
      s_rand = 2'($urandom_range(0, 2));
      k_rand = rand256();
      ct_rand = {$urandom(), $urandom(), $urandom(), $urandom()};
      ref_decrypt(s_rand, k_rand, ct_rand, exp_pt);
      run_block(s_rand, k_rand, ct_rand, exp_pt, 1'b1);
    end

    // Key latency: key_vld random.
    key_mode = 1;
    run_block(2'd0, {KEY_KAT[255:128], 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_KAT, 1'b0);
    k_rand = rand256();
    ct_rand = {$urandom(), $urandom(), $urandom(), $urandom()};
    ref_decrypt(2'd0, k_rand, ct_rand, exp_pt);
    run_block(2'd0, k_rand, ct_rand, exp_pt, 1'b0);
    key_mode = 0;

    // Output back-pressure with a second vector offered.
    start_block(2'd0, {KEY_KAT[255:128], 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_vld(1'b1, 10);
    ct = to_mat({$urandom(), $urandom(), $urandom(), $urandom()});
    ct_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aes_clk);
      check("hold_pt", obs_pt, to_mat(PT_KAT));
      check("hold_vld", 128'(obs_pvld), 128'(1));
      check("hold_ct_rdy", 128'(obs_rdy), 128'(0));
      check("hold_busy", 128'(obs_busy), 128'(1));
    end
    ct_vld = 1'b0;
    release_out();
    @(negedge aes_clk);
    check("no_second_accept", 128'(obs_busy), 128'(0));

    // Disable at rnd 5, then a fresh block.
    start_block(2'd0, {KEY_KAT[255:128], 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    n = 0;
    while (obs_ksel != 4'd5 && n < 50) begin
      @(negedge aes_clk);
      n++;
    end
    check("abort_at_rnd5", 128'(obs_ksel), 128'(5));
    aes_core_en = 1'b0;
    @(negedge aes_clk);
    check("abort_key_req", 128'(obs_kreq), 128'(0));
    check("abort_busy", 128'(obs_busy), 128'(0));
    check("abort_vld", 128'(obs_pvld), 128'(0));
    aes_core_en = 1'b1;
    repeat (12) @(negedge aes_clk);
    check("abort_no_vld", 128'(obs_pvld), 128'(0));
    k_rand = rand256();
    ct_rand = {$urandom(), $urandom(), $urandom(), $urandom()};
    ref_decrypt(2'd0, k_rand, ct_rand, exp_pt);
    run_block(2'd0, k_rand, ct_rand, exp_pt, 1'b1);

    // Reset mid-block at rnd 3, then a fresh block.
    start_block(2'd0, {KEY_KAT[255:128], 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    n = 0;
    while (obs_ksel != 4'd3 && n < 50) begin
      @(negedge aes_clk);
      n++;
    end
    check("reset_at_rnd3", 128'(obs_ksel), 128'(3));
    resetn = 1'b0;
    @(negedge aes_clk);
    check("mid_rst_pt", obs_pt, 128'(0));
    check("mid_rst_key_sel", 128'(obs_ksel), 128'(0));
    check("mid_rst_key_req", 128'(obs_kreq), 128'(0));
    check("mid_rst_busy", 128'(obs_busy), 128'(0));
    check("mid_rst_vld", 128'(obs_pvld), 128'(0));
    check("mid_rst_ct_rdy", 128'(obs_rdy), 128'(0));
    resetn = 1'b1;
    run_block(2'd0, {KEY_KAT[255:128], 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_KAT, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_decryp_iter_core.md
AES_DECRYP_ITER_CORE -- requirements
Module: aes_decryp_iter_core

Interface
REQ-001 SHALL have parameter NO_ROWS, default 4, state matrix rows (only 4 supported).
REQ-002 SHALL have parameter NO_COLS, default 4, state matrix columns (only 4 supported).
REQ-003 SHALL have parameter KEY_LEN, default 128, key length in bits; legal 128/192/256; NR = 6 + KEY_LEN/32 (10/12/14).
REQ-004 SHALL have ports:
- aes_clk  in  1  clock; one clock, all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- aes_core_en  in  1  core enable.
- cipher_text_i  in  [7:0] x[NO_ROWS-1:0][NO_COLS-1:0]  cipher text matrix.
- cipher_text_vld_i  in  1  cipher text valid.
- cipher_text_rdy_o  out  1  core can accept cipher text.
- key_req_o  out  1  round key request.
- key_sel_o  out  4  round key index requested.
- cipher_key_i  in  [7:0] x[NO_ROWS-1:0][NO_COLS-1:0]  round key matrix.
- key_vld_i  in  1  cipher_key_i holds key key_sel_o.
- plain_text_o  out  [7:0] x[NO_ROWS-1:0][NO_COLS-1:0]  plain text matrix.
- plain_text_vld_o  out  1  plain text valid.
- plain_text_rdy_i  in  1  downstream accepts plain text.
- aes_busy_o  out  1  block in progress or awaiting output handshake.

Function
REQ-005 Byte k (k=0 MSB) of a 128-bit FIPS-197 block SHALL map to matrix element [k%4][k/4].
REQ-006 FSM states SHALL be IDLE, ROUND, DONE; internal round counter rnd, 4 bits.
REQ-007 IDLE: cipher_text_rdy_o = aes_core_en; on edge with cipher_text_vld_i & cipher_text_rdy_o, state matrix <= cipher_text_i, rnd <= NR, go ROUND.
REQ-008 ROUND: key_req_o=1, key_sel_o=rnd; edges without key_vld_i SHALL change nothing (arbitrary key latency).
REQ-009 ROUND, key_vld_i=1, rnd==NR: state <= state ^ key; rnd <= rnd-1.
REQ-010 ROUND, key_vld_i=1, 0<rnd<NR: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key); rnd <= rnd-1.
REQ-011 ROUND, key_vld_i=1, rnd==0: plain_text_o <= InvSubBytes(InvShiftRows(state)) ^ key; plain_text_vld_o <= 1; go DONE.
REQ-012 InvShiftRows SHALL rotate row r right by r positions; InvSubBytes SHALL be a combinational 16-way inverse S-box; InvMixColumns SHALL use GF(2^8) coefficients 0E/0B/0D/09, reduction polynomial 0x11B.
REQ-013 Latency with key_vld_i held high SHALL be exactly NR+1 edges from acceptance edge to plain_text_vld_o rising.
REQ-014 DONE: plain_text_o and plain_text_vld_o SHALL hold stable until plain_text_rdy_i=1; on that edge vld_o <= 0, go IDLE; cipher_text_rdy_o=0 in DONE (no overlap).
REQ-015 key_req_o SHALL be 0 and key_sel_o SHALL hold its last value outside ROUND.
REQ-016 aes_busy_o SHALL be 1 in ROUND and DONE, 0 in IDLE.
REQ-017 aes_core_en=0 in any state: next edge go IDLE, key_req_o=0, plain_text_vld_o=0 (pending output dropped); plain_text_o not cleared.
REQ-018 aes_core_en=0 has priority over key_vld_i and plain_text_rdy_i in the same cycle.
REQ-019 cipher_text_vld_i while not ready SHALL be ignored; no data captured.
REQ-020 KEY_LEN not in {128,192,256} SHALL raise an elaboration-time $error.

Reset
REQ-021 resetn=0 at an edge SHALL force IDLE, rnd=0, state matrix and plain_text_o all zero, plain_text_vld_o=0, key_req_o=0, key_sel_o=0, aes_busy_o=0, overriding all other inputs including mid-operation.
REQ-022 cipher_text_rdy_o SHALL be 0 while resetn=0.

Verification
REQ-023 KEY_LEN=128, key_vld_i high, ct 69c4e0d86a7b0430d8cdb78070b4c55a, schedule of key 000102..0f -> pt 00112233445566778899aabbccddeeff, vld_o 11 edges after acceptance, key_sel_o 10 down to 0.
REQ-024 KEY_LEN=192, ct dda97ca4864cdfe06eaf70a0ec0d7191, key 000102..17 -> same pt, 13 edges; KEY_LEN=256, ct 8ea2b7ca516745bfeafc49904b496089, key 000102..1f -> same pt, 15 edges.
REQ-025 KEY_LEN=128, key_vld_i random ~50% -> same pt; no state change on edges with key_vld_i=0; key_sel_o stable while key_vld_i=0.
REQ-026 Hold plain_text_rdy_i=0 for 5 cycles after vld_o -> plain_text_o/vld_o stable, cipher_text_rdy_o=0, second vector not accepted; rdy_i=1 -> IDLE next edge.
REQ-027 Drop aes_core_en at rnd=5 -> IDLE next edge, key_req_o=0, no vld_o; new block then decrypts correctly.
REQ-028 Assert resetn=0 for one edge at rnd=3 -> all outputs reset per REQ-021; next vector decrypts correctly.
